// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM states and op decoding.
package alu_serial_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_AND;
    endfunction

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_seq_alu1bit.sv
// The ALU1bit slice: one result bit and carry-out per call, selected by the 3-bit op code.
module alu_serial_seq_alu1bit
    import alu_serial_pkg::*;
(
    input  logic       r2,
    input  logic       r3,
    input  logic       c_in,
    input  logic [2:0] select,
    output logic       out,
    output logic       c_out
);

    always_comb begin
        out   = 1'b0;
        c_out = 1'b0;
        case (select)
            OP_MOV: out = r2;
            OP_NOT: out = ~r2;
            OP_ADD: {c_out, out} = {1'b0, r2} + {1'b0, r3} + {1'b0, c_in};
            // Subtract as A + ~B with the sequencer seeding carry-in to 1.
            OP_SUB: {c_out, out} = {1'b0, r2} + {1'b0, ~r3} + {1'b0, c_in};
            OP_OR:  out = r2 | r3;
            OP_AND: out = r2 & r3;
            default: begin
                out   = 1'b0;
                c_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks one ALU1bit slice across WIDTH bits, LSB first, and
// presents the assembled result with carry/overflow/zero/error flags behind a start/done handshake.
module alu_serial_seq
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             v,
    output logic             zero,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [2:0]         op_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;

    logic               slice_out;
    logic               slice_cout;
    logic [WIDTH-1:0]   res_next;
    logic               last_bit;

    alu_serial_seq_alu1bit u_slice (
        .r2     (a_sr[0]),
        .r3     (b_sr[0]),
        .c_in   (carry_q),
        .select (op_q),
        .out    (slice_out),
        .c_out  (slice_cout)
    );

    assign res_next = {slice_out, res_sr[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            op_q    <= OP_MOV;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            c_out   <= 1'b0;
            v       <= 1'b0;
            zero    <= 1'b1;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (is_legal_op(op)) begin
                            a_sr    <= a;
                            b_sr    <= b;
                            op_q    <= op;
                            carry_q <= (op == OP_SUB);
                            cnt     <= '0;
                            res_sr  <= '0;
                            state   <= RUN;
                        end else begin
                            result <= '0;
                            c_out  <= 1'b0;
                            v      <= 1'b0;
                            zero   <= 1'b1;
                            err    <= 1'b1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_next;
                    carry_q <= slice_cout;
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB; xor with carry out gives overflow.
                        result <= res_next;
                        c_out  <= is_arith_op(op_q) ? slice_cout : 1'b0;
                        v      <= is_arith_op(op_q) ? (carry_q ^ slice_cout) : 1'b0;
                        zero   <= (res_next == '0);
                        err    <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed, illegal-op, randomized, held-start and
// mid-operation reset scenarios against an arithmetic reference model.
module tb_alu_serial_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         v;
    logic         zero;
    logic         err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Packed view of the completed-op outputs: {result, c_out, v, zero, err}
    typedef logic [W+3:0] pkt_t;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .v      (v),
        .zero   (zero),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic pkt_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         ov;
        logic         e;
        c  = 1'b0;
        ov = 1'b0;
        e  = 1'b0;
        r  = '0;
        case (o)
            3'd0: r = x;
            3'd1: r = ~x;
            3'd2: begin
                s  = {1'b0, x} + {1'b0, y};
                r  = s[W-1:0];
                c  = s[W];
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd3: begin
                s  = {1'b0, x} - {1'b0, y};
                r  = s[W-1:0];
                c  = (x >= y);
                ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd4: r = x | y;
            3'd5: r = x & y;
            default: e = 1'b1;
        endcase
        return {r, c, ov, (r == '0), e};
    endfunction

    // Issue one op from IDLE, wait for done (bounded), then step back into IDLE.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output pkt_t obs, output int lat, output logic busy_idle);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        lat   = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        obs = {result, c_out, v, zero, err};
        @(posedge clk);
        #1;
        busy_idle = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, result, c_out, v, zero, err} !== {2'b00, {W{1'b0}}, 4'b0010}) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b",
                     {busy, done, result, c_out, v, zero, err}, {2'b00, {W{1'b0}}, 4'b0010});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]   ops  [7] = '{3'd2, 3'd3, 3'd3, 3'd0, 3'd1, 3'd4, 3'd5};
        logic [W-1:0] as   [7] = '{8'h7F, 8'h05, 8'h05, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
        logic [W-1:0] bs   [7] = '{8'h01, 8'h07, 8'h05, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        pkt_t         exps [7] = '{{8'h80, 4'b0100}, {8'hFE, 4'b0000}, {8'h00, 4'b1010},
                                   {8'hC3, 4'b0000}, {8'h3C, 4'b0000}, {8'hDB, 4'b0000},
                                   {8'h42, 4'b0000}};
        pkt_t obs;
        int   lat;
        logic bi;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], obs, lat, bi);
            n_cmp++;
            if (obs !== exps[i]) begin
                n_fail++;
                $display("FAIL directed_%0d result/flags: got %h want %h", i, obs, exps[i]);
            end
            n_cmp++;
            if (lat !== W + 1) begin
                n_fail++;
                $display("FAIL directed_%0d latency: got %0d want %0d", i, lat, W + 1);
            end
            n_cmp++;
            if (bi !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_%0d busy_after_done: got %b want 0", i, bi);
            end
        end
    endtask

    task automatic test_illegal();
        pkt_t obs;
        int   lat;
        logic bi;
        for (int i = 6; i < 8; i++) begin
            issue(3'(i), W'($urandom), W'($urandom), obs, lat, bi);
            n_cmp++;
            if (obs !== {{W{1'b0}}, 4'b0011} || lat !== 1) begin
                n_fail++;
                $display("FAIL illegal_op_%0d: got %h lat %0d want %h lat 1",
                         i, obs, lat, {{W{1'b0}}, 4'b0011});
            end
        end
        issue(3'd0, 8'h5A, 8'h00, obs, lat, bi);
        n_cmp++;
        if (obs !== {8'h5A, 4'b0000}) begin
            n_fail++;
            $display("FAIL err_clear: got %h want %h", obs, {8'h5A, 4'b0000});
        end
    endtask

    task automatic test_random();
        pkt_t         obs;
        pkt_t         exp_p;
        int           lat;
        logic         bi;
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom);
            x = W'($urandom);
            y = (i % 8 == 0) ? x : W'($urandom);
            exp_p = model(o, x, y);
            issue(o, x, y, obs, lat, bi);
            n_cmp++;
            if (obs !== exp_p || lat !== ((o <= 3'd5) ? W + 1 : 1) || bi !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d op %0d a %h b %h: got %h lat %0d busy %b want %h",
                         i, o, x, y, obs, lat, bi, exp_p);
            end
        end
    endtask

    task automatic test_start_held();
        pkt_t exp_q[$];
        pkt_t exp_p;
        int   wt = 0;
        int   ndone = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 90; c++) begin
            op = 3'($urandom_range(0, 6));
            a  = W'($urandom);
            b  = W'($urandom);
            @(posedge clk);
            if (wt == 0) begin
                exp_q.push_back(model(op, a, b));
                wt = (op <= 3'd5) ? W + 1 : 1;
            end else begin
                wt--;
            end
            #1;
            n_cmp++;
            if (done !== (wt == 1)) begin
                n_fail++;
                $display("FAIL held_start_done cycle %0d: got %b want %b", c, done, wt == 1);
            end
            if (done && exp_q.size() > 0) begin
                exp_p = exp_q.pop_front();
                ndone++;
                n_cmp++;
                if ({result, c_out, v, zero, err} !== exp_p) begin
                    n_fail++;
                    $display("FAIL held_start_result %0d: got %h want %h",
                             ndone, {result, c_out, v, zero, err}, exp_p);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || ndone < 5) begin
            n_fail++;
            $display("FAIL held_start_drain: busy %b dones %0d want busy 0 dones >= 5", busy, ndone);
        end
    endtask

    task automatic test_mid_reset();
        pkt_t obs;
        int   lat;
        logic bi;
        int   seen = 0;
        issue(3'd0, 8'hC3, 8'h00, obs, lat, bi);
        @(negedge clk);
        start = 1'b1;
        op    = 3'd2;
        a     = 8'hFF;
        b     = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, result, c_out, v, zero, err} !== {2'b00, {W{1'b0}}, 4'b0010}) begin
            n_fail++;
            $display("FAIL mid_run_reset: got %b want %b",
                     {busy, done, result, c_out, v, zero, err}, {2'b00, {W{1'b0}}, 4'b0010});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", seen);
        end
        issue(3'd2, 8'h01, 8'h01, obs, lat, bi);
        n_cmp++;
        if (obs !== {8'h02, 4'b0000} || lat !== W + 1) begin
            n_fail++;
            $display("FAIL post_reset_add: got %h lat %0d want %h lat %0d",
                     obs, lat, {8'h02, 4'b0000}, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_start_held();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
